microwave_timer: RTL and testbench

Countdown timer core for the microwave controller. It accepts keypad digits into a three-digit BCD time register (minutes, seconds-tens, seconds-ones). On start it counts that time down once per 1 Hz tick while the door is closed. At zero it raises a completion pulse and a timed beep. Its BCD digit outputs feed the 7-segment display decoder directly, and `cooking` drives the magnetron/lamp enable.

---
 rtl/microwave_timer.sv | 134 +++++++++++++
 tb/tb_microwave_timer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer.sv
// Microwave countdown timer: BCD keypad entry, 1 Hz countdown,
// pause/resume on door or stop, and a timed completion beep.
module microwave_timer #(
    parameter int unsigned BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       cooking,
    output logic       done,
    output logic       beep
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BEEP_LAST = 4'(BEEP_TICKS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [11:0] tm;
    logic [11:0] tm_nxt;
    logic [11:0] tm_dec;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        done_q;
    logic        done_nxt;

    // Entered tens digits 6..9 just count down; only the minute
    // borrow reloads seconds with 59.
    function automatic logic [11:0] bcd_dec(input logic [11:0] t);
        logic [11:0] r;
        if (t[3:0] != 4'd0)
            r = {t[11:4], t[3:0] - 4'd1};
        else if (t[7:4] != 4'd0)
            r = {t[11:8], t[7:4] - 4'd1, 4'd9};
        else
            r = {t[11:8] - 4'd1, 4'd5, 4'd9};
        return r;
    endfunction

    assign tm_dec   = bcd_dec(tm);
    assign min      = tm[11:8];
    assign sec_tens = tm[7:4];
    assign sec_ones = tm[3:0];
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            tm     <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            tm     <= tm_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tm_nxt    = tm;
        cnt_nxt   = '0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear || stop) begin
                    tm_nxt = '0;
                end else if (start) begin
                    if (door_closed && tm != '0)
                        state_nxt = COOK;
                end else if (key_valid && key_digit <= 4'd9) begin
                    tm_nxt = {tm[7:0], key_digit};
                end
            end
            COOK: begin
                if (clear) begin
                    state_nxt = IDLE;
                    tm_nxt    = '0;
                end else if (stop || !door_closed) begin
                    state_nxt = PAUSE;
                end else if (tick) begin
                    tm_nxt = tm_dec;
                    if (tm_dec == '0) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (clear || stop) begin
                    state_nxt = IDLE;
                    tm_nxt    = '0;
                end else if (start && door_closed) begin
                    state_nxt = COOK;
                end
            end
            DONE: begin
                cnt_nxt = cnt;
                // Any user action ends the beep and is consumed.
                if (clear || stop || start || key_valid) begin
                    state_nxt = IDLE;
                    tm_nxt    = '0;
                end else if (tick) begin
                    if (cnt == BEEP_LAST)
                        state_nxt = IDLE;
                    else
                        cnt_nxt = cnt + 4'd1;
                end
            end
        endcase
    end

    always_comb begin
        cooking = (state == COOK);
        beep    = (state == DONE);
    end

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer: vector table, directed
// multi-cycle sequences and randomized traffic against a model.
module tb_microwave_timer;

    localparam int BT = 3;
    localparam int S_IDLE  = 0;
    localparam int S_COOK  = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       door_closed = 1'b1;
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       cooking;
    logic       done;
    logic       beep;

    int checks = 0;
    int errors = 0;

    microwave_timer #(.BEEP_TICKS(BT)) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .start(start),
        .stop(stop),
        .clear(clear),
        .door_closed(door_closed),
        .min(min),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .cooking(cooking),
        .done(done),
        .beep(beep)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       tk;
        logic       kv;
        logic [3:0] kd;
        logic       st;
        logic       sp;
        logic       cl;
        logic       dr;
        logic [11:0] t;
        logic       ck;
        logic       dn;
        logic       bp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, tk, kv,
                                input logic [3:0] kd,
                                input logic st, sp, cl, dr,
                                input logic [11:0] t,
                                input logic ck, dn, bp);
        vec_t v;
        v.rst = rst; v.tk = tk; v.kv = kv; v.kd = kd;
        v.st = st; v.sp = sp; v.cl = cl; v.dr = dr;
        v.t = t; v.ck = ck; v.dn = dn; v.bp = bp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [11:0] t,
                         input logic ck, dn, bp);
        logic [11:0] act;
        act = {min, sec_tens, sec_ones};
        checks++;
        if (act !== t || cooking !== ck || done !== dn || beep !== bp) begin
            errors++;
            $display("FAIL %s: got t=%h ck=%b dn=%b bp=%b want t=%h ck=%b dn=%b bp=%b",
                     name, act, cooking, done, beep, t, ck, dn, bp);
        end
    endtask

    // Drive one cycle of inputs from a falling edge, return at the next one.
    task automatic drive(input logic r, tk, kv, input logic [3:0] kd,
                         input logic st, sp, cl, dr);
        reset = r; tick = tk; key_valid = kv; key_digit = kd;
        start = st; stop = sp; clear = cl; door_closed = dr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic key(input logic [3:0] d);
        drive(0, 0, 1, d, 0, 0, 0, 1);
    endtask
    task automatic tk1();
        drive(0, 1, 0, 4'd0, 0, 0, 0, 1);
    endtask
    task automatic go();
        drive(0, 0, 0, 4'd0, 1, 0, 0, 1);
    endtask
    task automatic clr();
        drive(0, 0, 0, 4'd0, 0, 0, 1, 1);
    endtask
    task automatic nop();
        drive(0, 0, 0, 4'd0, 0, 0, 0, 1);
    endtask

    // Reference model: time held as the decimal value of the three digits.
    int mv, ms, mcnt;
    logic mdone;

    function automatic logic [11:0] bcd(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    task automatic model_step(input logic r, tk, kv, input logic [3:0] kd,
                              input logic st, sp, cl, dr);
        mdone = 1'b0;
        if (r) begin
            mv = 0; ms = S_IDLE; mcnt = 0;
        end else begin
            case (ms)
                S_IDLE: begin
                    if (cl || sp) mv = 0;
                    else if (st) begin
                        if (dr && mv != 0) ms = S_COOK;
                    end else if (kv && kd <= 9)
                        mv = (mv % 100) * 10 + int'(kd);
                end
                S_COOK: begin
                    if (cl) begin
                        ms = S_IDLE; mv = 0;
                    end else if (sp || !dr) ms = S_PAUSE;
                    else if (tk) begin
                        mv = (mv % 100 == 0) ? mv - 41 : mv - 1;
                        if (mv == 0) begin
                            ms = S_DONE; mdone = 1'b1; mcnt = 0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (cl || sp) begin
                        ms = S_IDLE; mv = 0;
                    end else if (st && dr) ms = S_COOK;
                end
                default: begin
                    if (cl || sp || st || kv) ms = S_IDLE;
                    else if (tk) begin
                        mcnt++;
                        if (mcnt == BT) ms = S_IDLE;
                    end
                end
            endcase
        end
    endtask

    initial begin
        @(negedge clk);

        // rst tk kv kd st sp cl dr | t ck dn bp
        add(1, 0, 0, 4'd0, 0, 0, 0, 1, 12'h000, 0, 0, 0);
        add(0, 0, 1, 4'd1, 0, 0, 0, 1, 12'h001, 0, 0, 0);
        add(0, 0, 1, 4'd3, 0, 0, 0, 1, 12'h013, 0, 0, 0);
        add(0, 0, 1, 4'd0, 0, 0, 0, 1, 12'h130, 0, 0, 0);
        add(0, 0, 1, 4'hC, 0, 0, 0, 1, 12'h130, 0, 0, 0);
        add(0, 0, 0, 4'd0, 0, 0, 1, 1, 12'h000, 0, 0, 0);
        add(0, 0, 1, 4'd1, 0, 0, 0, 1, 12'h001, 0, 0, 0);
        add(0, 0, 1, 4'd0, 0, 0, 0, 1, 12'h010, 0, 0, 0);
        add(0, 0, 1, 4'd0, 0, 0, 0, 1, 12'h100, 0, 0, 0);
        add(0, 0, 0, 4'd0, 1, 0, 0, 1, 12'h100, 1, 0, 0);
        add(0, 1, 0, 4'd0, 0, 0, 0, 1, 12'h059, 1, 0, 0);
        add(0, 0, 0, 4'd0, 0, 1, 0, 1, 12'h059, 0, 0, 0);
        add(0, 0, 0, 4'd0, 0, 0, 1, 1, 12'h000, 0, 0, 0);
        add(0, 0, 1, 4'd9, 0, 0, 0, 1, 12'h009, 0, 0, 0);
        add(0, 0, 1, 4'd0, 0, 0, 0, 1, 12'h090, 0, 0, 0);
        add(0, 0, 0, 4'd0, 1, 0, 0, 1, 12'h090, 1, 0, 0);
        add(0, 1, 0, 4'd0, 0, 0, 0, 1, 12'h089, 1, 0, 0);
        add(0, 0, 0, 4'd0, 0, 0, 1, 1, 12'h000, 0, 0, 0);
        add(0, 0, 1, 4'd4, 0, 0, 0, 1, 12'h004, 0, 0, 0);
        add(0, 0, 1, 4'd5, 0, 0, 0, 1, 12'h045, 0, 0, 0);
        add(0, 0, 0, 4'd0, 1, 0, 0, 1, 12'h045, 1, 0, 0);
        add(0, 1, 0, 4'd0, 0, 0, 0, 0, 12'h045, 0, 0, 0);
        add(0, 1, 0, 4'd0, 0, 0, 0, 0, 12'h045, 0, 0, 0);
        add(0, 1, 0, 4'd0, 0, 0, 0, 1, 12'h045, 0, 0, 0);
        add(0, 0, 0, 4'd0, 1, 0, 0, 0, 12'h045, 0, 0, 0);
        add(0, 0, 0, 4'd0, 1, 0, 0, 1, 12'h045, 1, 0, 0);
        add(0, 1, 0, 4'd0, 0, 0, 0, 1, 12'h044, 1, 0, 0);
        add(0, 1, 0, 4'd0, 0, 1, 0, 1, 12'h044, 0, 0, 0);
        add(0, 0, 0, 4'd0, 0, 1, 0, 1, 12'h000, 0, 0, 0);
        add(0, 0, 1, 4'd5, 0, 0, 0, 1, 12'h005, 0, 0, 0);
        add(0, 0, 0, 4'd0, 1, 0, 1, 1, 12'h000, 0, 0, 0);
        add(0, 0, 0, 4'd0, 1, 0, 0, 1, 12'h000, 0, 0, 0);
        add(0, 0, 1, 4'd7, 0, 0, 0, 1, 12'h007, 0, 0, 0);
        add(0, 0, 0, 4'd0, 1, 0, 0, 0, 12'h007, 0, 0, 0);
        add(0, 0, 1, 4'd2, 1, 0, 0, 0, 12'h007, 0, 0, 0);
        add(0, 0, 0, 4'd0, 1, 0, 0, 1, 12'h007, 1, 0, 0);
        add(0, 0, 1, 4'd8, 0, 0, 0, 1, 12'h007, 1, 0, 0);
        add(0, 0, 0, 4'd0, 0, 0, 1, 1, 12'h000, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].tk, vecs[i].kv, vecs[i].kd,
                  vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].dr);
            check($sformatf("vec%0d", i), vecs[i].t, vecs[i].ck,
                  vecs[i].dn, vecs[i].bp);
        end

        // Completion and beep timeout
        key(4'd0);  check("done_k0", 12'h000, 0, 0, 0);
        key(4'd2);  check("done_k2", 12'h002, 0, 0, 0);
        go();       check("done_go", 12'h002, 1, 0, 0);
        tk1();      check("done_t1", 12'h001, 1, 0, 0);
        tk1();      check("done_t2", 12'h000, 0, 1, 1);
        nop();      check("done_pulse", 12'h000, 0, 0, 1);
        tk1();      check("beep_t1", 12'h000, 0, 0, 1);
        tk1();      check("beep_t2", 12'h000, 0, 0, 1);
        tk1();      check("beep_t3", 12'h000, 0, 0, 0);
        key(4'd3);  check("after_beep", 12'h003, 0, 0, 0);

        // Key press cuts the beep short and is consumed
        clr();      check("rep_clr", 12'h000, 0, 0, 0);
        key(4'd2);  check("rep_k2", 12'h002, 0, 0, 0);
        go();       check("rep_go", 12'h002, 1, 0, 0);
        tk1();      check("rep_t1", 12'h001, 1, 0, 0);
        tk1();      check("rep_t2", 12'h000, 0, 1, 1);
        key(4'd7);  check("rep_key_exit", 12'h000, 0, 0, 0);
        key(4'd7);  check("rep_idle_key", 12'h007, 0, 0, 0);

        // Reset mid-cook
        clr();      check("rst_clr", 12'h000, 0, 0, 0);
        key(4'd5);
        key(4'd3);
        key(4'd7);  check("rst_537", 12'h537, 0, 0, 0);
        go();       check("rst_go", 12'h537, 1, 0, 0);
        drive(1, 1, 0, 4'd0, 0, 0, 0, 1);
        check("rst_mid", 12'h000, 0, 0, 0);
        key(4'd1);  check("rst_idle", 12'h001, 0, 0, 0);

        // Randomized traffic against the model
        model_step(1, 0, 0, 4'd0, 0, 0, 0, 1);
        drive(1, 0, 0, 4'd0, 0, 0, 0, 1);
        check("rand_rst", bcd(mv), ms == S_COOK, mdone, ms == S_DONE);
        for (int i = 0; i < 3000; i++) begin
            logic r, tk, kv, st, sp, cl, dr;
            logic [3:0] kd;
            r  = ($urandom_range(0, 299) == 0);
            tk = ($urandom_range(0, 99) < 40);
            kv = ($urandom_range(0, 99) < 30);
            kd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(0, 2));
            st = ($urandom_range(0, 99) < 15);
            sp = ($urandom_range(0, 99) < 4);
            cl = ($urandom_range(0, 99) < 3);
            dr = ($urandom_range(0, 9) != 0);
            model_step(r, tk, kv, kd, st, sp, cl, dr);
            drive(r, tk, kv, kd, st, sp, cl, dr);
            check($sformatf("rand%0d", i), bcd(mv), ms == S_COOK,
                  mdone, ms == S_DONE);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
